// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline memory path: word type, arbiter states, timeout error word.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam word_t ERR_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-ported RAM.
// Define ARB_TIMEOUT_EN to force an error response after TIMEOUT_CYCLES without ram_ready.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              arb_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t        state;
  arb_state_t        next_state;
  logic              dreq;
  logic              acc_timeout;
  logic              acc_done;
  logic [DATA_W-1:0] resp_word;

  assign dreq = dREN | dWEN;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign acc_timeout = !ram_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_word   = acc_timeout ? DATA_W'(ERR_WORD) : ramload;
  assign arb_err     = err_q;
`else
  assign acc_timeout = 1'b0;
  assign resp_word   = ramload;
  assign arb_err     = 1'b0;
`endif

  assign acc_done = ram_ready | acc_timeout;

  // NOTE: next_state gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dreq)      next_state = DACC;
        else if (iREN) next_state = IACC;
      end
      DACC, IACC: if (acc_done) next_state = RESP;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state <= next_state;
      ihit  <= 1'b0;
      dhit  <= 1'b0;
      iload <= '0;
      dload <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q    <= 1'b0;
      wait_cnt <= (state == DACC || state == IACC) ? wait_cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: begin
          // Both dREN and dWEN set is treated as a write.
          if (dreq) begin
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dWEN ? dstore : '0;
          end else if (iREN) begin
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= iaddr;
            ramstore <= '0;
          end
        end
        DACC, IACC: begin
          if (acc_done) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (state == DACC) begin
              dhit  <= 1'b1;
              dload <= (ramWEN && !acc_timeout) ? '0 : resp_word;
            end else begin
              ihit  <= 1'b1;
              iload <= resp_word;
            end
`ifdef ARB_TIMEOUT_EN
            err_q <= acc_timeout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed corner cases, then randomized traffic
// checked against a reference memory and a behavioural RAM with random latency.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        ihit, dhit, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ram_ready = 1'b0;
  logic [31:0] ramload = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   i_hits = 0;
  int   d_hits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unwritten memory reads back a fixed scramble of its address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference memory: what every address must hold, updated when a write is issued.
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Behavioural RAM: independent storage, latency 0..3 cycles or a forced value.
  logic [31:0] ram_arr [logic [31:0]];
  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return ram_arr.exists(a) ? ram_arr[a] : init_word(a);
  endfunction

  int          ram_lat_fix = -1;
  int          ram_left = 0;
  bit          ram_busy = 1'b0;
  int          strobe_cycles = 0;
  int          last_strobe_cycles = 0;
  logic [31:0] cap_addr, cap_store;
  logic        cap_wen;

  initial begin
    forever begin
      @(negedge CLK);
      ram_ready = 1'b0;
      ramload   = '0;
      if (!nRST || !(ramREN || ramWEN)) begin
        ram_busy = 1'b0;
      end else begin
        if (!ram_busy) begin
          ram_busy      = 1'b1;
          ram_left      = (ram_lat_fix < 0) ? int'($urandom_range(0, 3)) : ram_lat_fix;
          strobe_cycles = 0;
          cap_addr      = ramaddr;
          cap_store     = ramstore;
          cap_wen       = ramWEN;
        end else begin
          check("ram_addr_stable", ramaddr, cap_addr);
          check("ram_store_stable", ramstore, cap_store);
          check("ram_wen_stable", 32'(ramWEN), 32'(cap_wen));
        end
        strobe_cycles++;
        if (ram_left == 0) begin
          ram_ready          = 1'b1;
          last_strobe_cycles = strobe_cycles;
          if (ramWEN) ram_arr[ramaddr] = ramstore;
          else        ramload = ram_read(ramaddr);
        end else begin
          ram_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a hit pulse is presented.
  always @(negedge CLK) begin
    if (nRST) begin
      if (ramREN || ramWEN) begin
        check("strobe_exclusive", 32'(ramREN & ramWEN), 32'd0);
        check("arb_err_during_access", 32'(arb_err), 32'd0);
      end
      if (ihit || dhit) check("hit_exclusive", 32'(ihit & dhit), 32'd0);
      if (ihit) begin
        exp_t e;
        i_hits++;
        check("ihit_expected", 32'(iq.size() != 0), 32'd1);
        if (iq.size() != 0) begin
          e = iq.pop_front();
          check("iload", iload, e.data);
          check("ihit_arb_err", 32'(arb_err), 32'(e.err));
        end
      end
      if (dhit) begin
        exp_t e;
        d_hits++;
        check("dhit_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          check("dload", dload, e.data);
          check("dhit_arb_err", 32'(arb_err), 32'(e.err));
        end
      end
    end
  end

  // Requests are raised at a negedge, held until the hit, then held through the
  // following edge (the RESP cycle) as a real pipeline latch would.
  task automatic ifetch(input logic [31:0] a, input int bound, output int lat);
    exp_t e;
    int   t0;
    bit   got;
    e.data = ref_read(a);
    e.err  = 1'b0;
    iq.push_back(e);
    iREN  = 1'b1;
    iaddr = a;
    t0    = cyc;
    got   = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge CLK);
      if (ihit) begin
        got = 1'b1;
        break;
      end
    end
    lat = cyc - t0;
    check("ihit_within_bound", 32'(got), 32'd1);
    @(posedge CLK);
    #1;
    iREN  = 1'b0;
    iaddr = $urandom;
    @(negedge CLK);
  endtask

  task automatic dacc(input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] wdata, input bit tmo, input int bound,
                      output int lat);
    exp_t e;
    int   t0;
    bit   got;
    if (tmo) begin
      e.data = ERR_WORD;
      e.err  = 1'b1;
    end else if (wr) begin
      e.data   = '0;
      e.err    = 1'b0;
      ref_mem[a] = wdata;
    end else begin
      e.data = ref_read(a);
      e.err  = 1'b0;
    end
    dq.push_back(e);
    dWEN   = wr;
    dREN   = rd;
    daddr  = a;
    dstore = wdata;
    t0     = cyc;
    got    = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge CLK);
      if (dhit) begin
        got = 1'b1;
        break;
      end
    end
    lat = cyc - t0;
    check("dhit_within_bound", 32'(got), 32'd1);
    @(posedge CLK);
    #1;
    dWEN   = 1'b0;
    dREN   = 1'b0;
    daddr  = $urandom;
    dstore = $urandom;
    @(negedge CLK);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, ilat, dlat, d0;

    // Reset state.
    #1;
    check("reset_hits", {30'd0, ihit, dhit}, 32'd0);
    check("reset_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    check("reset_iload", iload, 32'd0);
    check("reset_dload", dload, 32'd0);
    check("reset_ramaddr", ramaddr, 32'd0);
    check("reset_ramstore", ramstore, 32'd0);
    check("reset_arb_err", 32'(arb_err), 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Reset while a write is in flight drops the strobe at once; no dhit afterwards.
    ram_lat_fix = 10;
    dWEN   = 1'b1;
    daddr  = 32'h0000_1100;
    dstore = 32'h1111_2222;
    @(negedge CLK);
    check("midacc_wen_before_reset", 32'(ramWEN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("midacc_wen_after_reset", 32'(ramWEN), 32'd0);
    check("midacc_state_after_reset", 32'(dut.state), 32'(IDLE));
    dWEN = 1'b0;
    d0   = d_hits;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (6) @(negedge CLK);
    check("midacc_no_dhit", 32'(d_hits - d0), 32'd0);
    check("midacc_no_strobe", {30'd0, ramREN, ramWEN}, 32'd0);

    // Instruction fetch with zero wait: hit two cycles after the request.
    ram_lat_fix = 0;
    ref_mem[32'h40] = 32'h2008_0001;
    ram_arr[32'h40] = 32'h2008_0001;
    ifetch(32'h40, 50, lat);
    check("ifetch_latency", 32'(lat), 32'd2);

    // Simultaneous requests: data first, instruction at least two cycles later.
    fork
      ifetch(32'h0000_0300, 50, ilat);
      dacc(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 50, dlat);
    join
    check("prio_data_latency", 32'(dlat), 32'd2);
    check("prio_i_after_d", 32'(ilat - dlat >= 2), 32'd1);

    // Write with three wait states: strobe held four cycles, then read it back.
    ram_lat_fix = 3;
    dacc(1'b1, 1'b0, 32'h80, 32'hDEAD_BEEF, 1'b0, 50, lat);
    check("write_strobe_cycles", 32'(last_strobe_cycles), 32'd4);
    check("write_latency", 32'(lat), 32'd5);
    dacc(1'b0, 1'b1, 32'h80, 32'h0, 1'b0, 50, lat);

    // Both dREN and dWEN set is served as a write.
    ram_lat_fix = 1;
    dacc(1'b1, 1'b1, 32'h84, 32'hCAFE_F00D, 1'b0, 50, lat);
    dacc(1'b0, 1'b1, 32'h84, 32'h0, 1'b0, 50, lat);

    // Back-to-back reads with the request held through RESP: one hit per access.
    ram_lat_fix = 0;
    d0 = d_hits;
    for (int k = 0; k < 3; k++) dacc(1'b0, 1'b1, 32'h88, 32'h0, 1'b0, 50, lat);
    repeat (4) @(negedge CLK);
    check("b2b_hit_count", 32'(d_hits - d0), 32'd3);

`ifdef ARB_TIMEOUT_EN
    // RAM never answers: forced error response after 64 access cycles.
    ram_lat_fix = 1_000_000;
    dacc(1'b0, 1'b1, 32'h200, 32'h0, 1'b1, 200, lat);
    check("timeout_latency", 32'(lat), 32'd65);
`endif

    // Randomized concurrent traffic; writes stay in 0x1000.. so fetches are unaffected.
    ram_lat_fix = -1;
    fork
      begin
        int l;
        for (int n = 0; n < 40; n++) begin
          for (int g = 0; g < int'($urandom_range(0, 4)); g++) @(negedge CLK);
          ifetch(32'($urandom_range(0, 1023)) << 2, 3000, l);
        end
      end
      begin
        int          l;
        int          op;
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
          for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge CLK);
          op = int'($urandom_range(0, 5));
          a  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
          case (op)
            0, 1:    dacc(1'b1, 1'b0, a, $urandom, 1'b0, 3000, l);
            2:       dacc(1'b1, 1'b1, a, $urandom, 1'b0, 3000, l);
            3:       dacc(1'b0, 1'b1, 32'($urandom_range(0, 1023)) << 2, 32'h0, 1'b0, 3000, l);
            default: dacc(1'b0, 1'b1, a, 32'h0, 1'b0, 3000, l);
          endcase
        end
      end
    join

    repeat (6) @(negedge CLK);
    check("iq_drained", 32'(iq.size()), 32'd0);
    check("dq_drained", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
